// File: rtl/fpu_ctrl_pkg.sv
// Shared definitions for the FPU issue controller and FPU clients:
// funct5 opcodes, controller state encoding and default op latencies.
package fpu_ctrl_pkg;

  localparam logic [4:0] OpAdd    = 5'b00000;
  localparam logic [4:0] OpSub    = 5'b00001;
  localparam logic [4:0] OpMul    = 5'b00010;
  localparam logic [4:0] OpDiv    = 5'b00011;
  localparam logic [4:0] OpSgnj   = 5'b00100;
  localparam logic [4:0] OpMinMax = 5'b00101;
  localparam logic [4:0] OpSqrt   = 5'b01011;
  localparam logic [4:0] OpCmp    = 5'b10100;
  localparam logic [4:0] OpCvtWS  = 5'b11000;
  localparam logic [4:0] OpCvtSW  = 5'b11010;
  localparam logic [4:0] OpMvXW   = 5'b11100;
  localparam logic [4:0] OpMvWX   = 5'b11110;

  localparam int unsigned DefaultLatAdd  = 2;
  localparam int unsigned DefaultLatMul  = 2;
  localparam int unsigned DefaultLatDiv  = 8;
  localparam int unsigned DefaultLatSqrt = 8;
  localparam int unsigned DefaultLatMisc = 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  typedef enum logic [2:0] {ClsAdd, ClsMul, ClsDiv, ClsSqrt, ClsMisc, ClsNone} op_class_e;

  // ClsNone marks an opcode the FPU does not implement.
  function automatic op_class_e op_class(input logic [4:0] f5);
    case (f5)
      OpAdd, OpSub: return ClsAdd;
      OpMul:        return ClsMul;
      OpDiv:        return ClsDiv;
      OpSqrt:       return ClsSqrt;
      OpSgnj, OpMinMax, OpCmp, OpCvtWS, OpCvtSW, OpMvXW, OpMvWX: return ClsMisc;
      default:      return ClsNone;
    endcase
  endfunction

endpackage

// File: rtl/fpu.sv
// Combinational single-precision datapath: round-toward-zero, denormals flushed
// to zero, no NaN/infinity propagation. rm selects the sign-inject/min-max/compare variant.
module fpu
  import fpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [4:0]  funct5,
  input  logic [2:0]  rm,
  output logic [31:0] res
);

  // The datapath is purely combinational; clk is kept for a pipelined variant.
  logic unused_clk;
  assign unused_clk = clk;

  function automatic logic [31:0] pack(input logic s, input int e, input logic [22:0] m);
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 8'hff, 23'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [26:0] mb, ms;
    logic [27:0] sum;
    logic [7:0]  d;
    int          e;
    if (a[30:0] >= b[30:0]) begin big = a; sml = b; end
    else begin big = b; sml = a; end
    if (big[30:23] == 8'd0) return 32'h0;
    mb  = {1'b1, big[22:0], 3'b000};
    ms  = (sml[30:23] == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
    d   = big[30:23] - sml[30:23];
    ms  = (d > 8'd26) ? 27'd0 : ms >> d;
    sum = (big[31] == sml[31]) ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
    if (sum == 28'd0) return 32'h0;
    e = int'(big[30:23]);
    if (sum[27]) begin
      sum = sum >> 1;
      e   = e + 1;
    end
    for (int i = 0; i < 26; i++) begin
      if (!sum[26]) begin
        sum = sum << 1;
        e   = e - 1;
      end
    end
    return pack(big[31], e, sum[25:3]);
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return pack(s, e + 1, p[46:24]);
    return pack(s, e, p[45:23]);
  endfunction

  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [48:0] q;
    int          e;
    s = a[31] ^ b[31];
    if (b[30:23] == 8'd0) return {s, 8'hff, 23'd0};
    if (a[30:23] == 8'd0) return {s, 31'd0};
    q = {1'b1, a[22:0], 25'd0} / {25'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[25]) return pack(s, e, q[24:2]);
    return pack(s, e - 1, q[23:1]);
  endfunction

  function automatic logic [31:0] fp_sqrt(input logic [31:0] a);
    logic [47:0] rad;
    logic [27:0] rem, trial;
    logic [23:0] r;
    int          e;
    if (a[30:23] == 8'd0) return {a[31], 31'd0};
    if (a[31]) return 32'h7fc00000;
    e = int'(a[30:23]) - 127;
    // Fold an odd exponent into the radicand so the result exponent is e/2.
    if (e[0]) begin
      rad = {1'b1, a[22:0], 24'd0};
      e   = e - 1;
    end else begin
      rad = {1'b0, 1'b1, a[22:0], 23'd0};
    end
    rem = 28'd0;
    r   = 24'd0;
    for (int i = 23; i >= 0; i--) begin
      rem   = {rem[25:0], rad[2*i +: 2]};
      trial = {2'b00, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[22:0], 1'b1};
      end else begin
        r   = {r[22:0], 1'b0};
      end
    end
    return pack(1'b0, e / 2 + 127, r[22:0]);
  endfunction

  function automatic logic [31:0] cvt_w_s(input logic [31:0] a);
    logic [31:0] mag;
    int          e;
    e = int'(a[30:23]) - 127;
    if (a[30:23] == 8'd0 || e < 0) return 32'h0;
    if (e > 30) return a[31] ? 32'h80000000 : 32'h7fffffff;
    mag = {8'd0, 1'b1, a[22:0]};
    mag = (e >= 23) ? mag << (e - 23) : mag >> (23 - e);
    return a[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] cvt_s_w(input logic [31:0] a);
    logic [31:0] mag;
    int          p;
    if (a == 32'h0) return 32'h0;
    mag = a[31] ? -a : a;
    p   = 0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) p = i;
    end
    mag = mag << (31 - p);
    return {a[31], 8'(127 + p), mag[30:8]};
  endfunction

  function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31] && ((a[30:0] | b[30:0]) != 31'd0);
    return a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
  endfunction

  function automatic logic feq(input logic [31:0] a, input logic [31:0] b);
    return (a == b) || ((a[30:0] | b[30:0]) == 31'd0);
  endfunction

  always_comb begin
    res = 32'h0;
    case (funct5)
      OpAdd:    res = fp_add(x, y);
      OpSub:    res = fp_add(x, {~y[31], y[30:0]});
      OpMul:    res = fp_mul(x, y);
      OpDiv:    res = fp_div(x, y);
      OpSqrt:   res = fp_sqrt(x);
      OpSgnj: begin
        case (rm)
          3'b000:  res = {y[31], x[30:0]};
          3'b001:  res = {~y[31], x[30:0]};
          3'b010:  res = {x[31] ^ y[31], x[30:0]};
          default: res = 32'h0;
        endcase
      end
      OpMinMax: res = (rm[0] ^ flt(x, y)) ? x : y;
      OpCmp: begin
        case (rm)
          3'b000:  res = {31'd0, flt(x, y) | feq(x, y)};
          3'b001:  res = {31'd0, flt(x, y)};
          3'b010:  res = {31'd0, feq(x, y)};
          default: res = 32'h0;
        endcase
      end
      OpCvtWS:  res = cvt_w_s(x);
      OpCvtSW:  res = cvt_s_w(x);
      OpMvXW, OpMvWX: res = x;
      default:  res = 32'h0;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller: latches one request, waits the
// opcode's fixed latency, then holds the result until the consumer takes it.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned LAT_ADD  = DefaultLatAdd,
  parameter int unsigned LAT_MUL  = DefaultLatMul,
  parameter int unsigned LAT_DIV  = DefaultLatDiv,
  parameter int unsigned LAT_SQRT = DefaultLatSqrt,
  parameter int unsigned LAT_MISC = DefaultLatMisc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  input  logic [4:0]  req_funct5,
  input  logic [2:0]  req_rm,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] x_q, y_q;
  logic [4:0]  funct5_q;
  logic [2:0]  rm_q;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic [31:0] fpu_res;
  logic        accept;

  function automatic logic [3:0] op_latency(input logic [4:0] f5);
    case (op_class(f5))
      ClsAdd:  return 4'(LAT_ADD);
      ClsMul:  return 4'(LAT_MUL);
      ClsDiv:  return 4'(LAT_DIV);
      ClsSqrt: return 4'(LAT_SQRT);
      ClsMisc: return 4'(LAT_MISC);
      default: return 4'd1;
    endcase
  endfunction

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign accept     = req_valid & req_ready;

  fpu u_fpu (
    .clk    (clk),
    .x      (x_q),
    .y      (y_q),
    .funct5 (funct5_q),
    .rm     (rm_q),
    .res    (fpu_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StBusy;
          cnt_d   = op_latency(req_funct5);
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        // The edge that takes the counter to zero captures the result.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StDone;
          if (op_class(funct5_q) == ClsNone) begin
            data_d = 32'h0;
            err_d  = 1'b1;
          end else begin
            data_d = fpu_res;
            err_d  = 1'b0;
          end
        end
      end
      StDone: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= 32'h0;
      y_q      <= 32'h0;
      funct5_q <= 5'd0;
      rm_q     <= 3'd0;
    end else if (accept) begin
      x_q      <= req_x;
      y_q      <= req_y;
      funct5_q <= req_funct5;
      rm_q     <= req_rm;
    end
  end

endmodule
